// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - data-cache line entry and byte-enable layout shared by the tag stage
package std_cache_pkg;
    localparam int DEFAULT_SET_ASSOC   = 8;
    localparam int DEFAULT_INDEX_WIDTH = 12;
    localparam int DEFAULT_TAG_WIDTH   = 44;
    localparam int DEFAULT_LINE_WIDTH  = 128;
    localparam int FLAG_BITS           = 3;

    // One way entry is {data, tag, dirty, valid, shared}, shared at bit 0.
    localparam int SHARED_BIT = 0;
    localparam int VALID_BIT  = 1;
    localparam int DIRTY_BIT  = 2;
    localparam int TAG_LSB    = 3;

    function automatic int line_entry_width(input int line_w, input int tag_w);
        return line_w + tag_w + FLAG_BITS;
    endfunction

    // Byte enables are {data_be, tag_be, vldrty}, with one vldrty bit per way at the bottom.
    function automatic int be_width(input int line_w, input int tag_w, input int set_assoc);
        return line_w / 8 + tag_w / 8 + set_assoc;
    endfunction
endpackage

// File: rtl/rr_starve_arbiter.sv
// rtl/rr_starve_arbiter.sv - fixed-priority plus round-robin arbiter with starvation escalation
module rr_starve_arbiter #(
    parameter int NR_PORTS      = 5,
    parameter int NR_FIXED_PRIO = 2,
    parameter int STARVE_LIMIT  = 16,
    localparam int IDW          = $clog2(NR_PORTS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NR_PORTS-1:0] req_i,
    output logic [NR_PORTS-1:0] gnt_o,
    output logic [IDW-1:0]      id_o,
    output logic                valid_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [IDW-1:0] PTR_RST = IDW'(NR_FIXED_PRIO);
    localparam logic [SW-1:0]  LIMIT   = SW'(STARVE_LIMIT);

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [IDW-1:0] rr_idx, fix_idx;
    logic           rr_found, fix_found, rr_win;

    // Two passes give the first requester at/after the pointer, then the wrapped part.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = NR_FIXED_PRIO; i < NR_PORTS; i++) begin
            if (!rr_found && req_i[i] && i >= int'(rr_ptr_q)) begin
                rr_found = 1'b1;
                rr_idx   = IDW'(i);
            end
        end
        for (int i = NR_FIXED_PRIO; i < NR_PORTS; i++) begin
            if (!rr_found && req_i[i] && i < int'(rr_ptr_q)) begin
                rr_found = 1'b1;
                rr_idx   = IDW'(i);
            end
        end
    end

    always_comb begin
        fix_found = 1'b0;
        fix_idx   = '0;
        for (int i = 0; i < NR_FIXED_PRIO; i++) begin
            if (!fix_found && req_i[i]) begin
                fix_found = 1'b1;
                fix_idx   = IDW'(i);
            end
        end
    end

    always_comb begin
        rr_win  = rr_found && (starve_q == LIMIT || !fix_found);
        valid_o = rr_found || fix_found;
        id_o    = rr_win ? rr_idx : fix_idx;
        for (int i = 0; i < NR_PORTS; i++) begin
            gnt_o[i] = valid_o && (id_o == IDW'(i));
        end

        rr_ptr_d = rr_ptr_q;
        if (rr_win) begin
            rr_ptr_d = (rr_idx == IDW'(NR_PORTS - 1)) ? PTR_RST : rr_idx + IDW'(1);
        end

        if (NR_FIXED_PRIO == 0 || rr_win || !rr_found) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= PTR_RST;
            starve_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: rtl/dcache_tag_arbiter.sv
// rtl/dcache_tag_arbiter.sv - N-port SRAM arbiter with one-cycle tag compare and read strobes
module dcache_tag_arbiter
    import std_cache_pkg::*;
#(
    parameter int NR_PORTS      = 5,
    parameter int NR_FIXED_PRIO = 2,
    parameter int SET_ASSOC     = DEFAULT_SET_ASSOC,
    parameter int INDEX_WIDTH   = DEFAULT_INDEX_WIDTH,
    parameter int TAG_WIDTH     = DEFAULT_TAG_WIDTH,
    parameter int LINE_WIDTH    = DEFAULT_LINE_WIDTH,
    parameter int STARVE_LIMIT  = 16,
    localparam int RW           = line_entry_width(LINE_WIDTH, TAG_WIDTH),
    localparam int BW           = be_width(LINE_WIDTH, TAG_WIDTH, SET_ASSOC)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NR_PORTS*SET_ASSOC-1:0]    req_i,
    input  logic [NR_PORTS*INDEX_WIDTH-1:0]  addr_i,
    input  logic [NR_PORTS*TAG_WIDTH-1:0]    tag_i,
    input  logic [NR_PORTS-1:0]              we_i,
    input  logic [NR_PORTS*RW-1:0]           wdata_i,
    input  logic [NR_PORTS*BW-1:0]           be_i,
    output logic [NR_PORTS-1:0]              gnt_o,
    output logic [NR_PORTS-1:0]              rvalid_o,
    output logic [SET_ASSOC*RW-1:0]          rdata_o,
    output logic [SET_ASSOC-1:0]             hit_way_o,
    output logic [SET_ASSOC-1:0]             dirty_way_o,
    output logic [SET_ASSOC-1:0]             shared_way_o,
    output logic [SET_ASSOC-1:0]             req_o,
    output logic [INDEX_WIDTH-1:0]           addr_o,
    output logic                             we_o,
    output logic [RW-1:0]                    wdata_o,
    output logic [BW-1:0]                    be_o,
    input  logic [SET_ASSOC*RW-1:0]          rdata_i
);
    localparam int IDW = $clog2(NR_PORTS);

    logic [NR_PORTS-1:0]  port_req, gnt;
    logic [IDW-1:0]       win_id, id_q, id_d;
    logic                 win_valid, rd_q, rd_d;
    logic [TAG_WIDTH-1:0] cmp_tag;

    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) begin
            port_req[p] = |req_i[p*SET_ASSOC +: SET_ASSOC];
        end
    end

    rr_starve_arbiter #(
        .NR_PORTS      (NR_PORTS),
        .NR_FIXED_PRIO (NR_FIXED_PRIO),
        .STARVE_LIMIT  (STARVE_LIMIT)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (port_req),
        .gnt_o   (gnt),
        .id_o    (win_id),
        .valid_o (win_valid)
    );

    assign gnt_o = gnt;

    // Grant is one-hot, so selecting by it leaves everything 0 when nobody requests.
    always_comb begin
        req_o   = '0;
        addr_o  = '0;
        we_o    = 1'b0;
        wdata_o = '0;
        be_o    = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (gnt[p]) begin
                req_o   = req_i[p*SET_ASSOC +: SET_ASSOC];
                addr_o  = addr_i[p*INDEX_WIDTH +: INDEX_WIDTH];
                we_o    = we_i[p];
                wdata_o = wdata_i[p*RW +: RW];
                be_o    = be_i[p*BW +: BW];
            end
        end
    end

    assign rd_d = win_valid && !we_o;
    assign id_d = rd_d ? win_id : id_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= 1'b0;
            id_q <= '0;
        end else begin
            rd_q <= rd_d;
            id_q <= id_d;
        end
    end

    // The requester presents its compare tag in the cycle its SRAM data returns.
    always_comb begin
        cmp_tag = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            rvalid_o[p] = rd_q && (id_q == IDW'(p));
            if (id_q == IDW'(p)) begin
                cmp_tag = tag_i[p*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    always_comb begin
        for (int w = 0; w < SET_ASSOC; w++) begin
            hit_way_o[w]    = rd_q && rdata_i[w*RW + VALID_BIT]
                              && (rdata_i[w*RW + TAG_LSB +: TAG_WIDTH] == cmp_tag);
            dirty_way_o[w]  = rd_q && rdata_i[w*RW + DIRTY_BIT];
            shared_way_o[w] = rd_q && rdata_i[w*RW + SHARED_BIT];
        end
    end

    assign rdata_o = rdata_i;

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(hit_way_o));
        end
    end
endmodule
